// File: rtl/key_debouncer_pkg.sv
// Shared types and helpers for the stopwatch front-panel key debouncer.
package key_debouncer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } key_state_e;

    // Milliseconds to clock cycles, never below two so counters keep at least one bit.
    function automatic int unsigned ms_to_cycles(input int unsigned freq, input int unsigned ms);
        int unsigned cycles;
        cycles = freq / 1000 * ms;
        return (cycles < 2) ? 2 : cycles;
    endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One key: 2-flop synchroniser, stability counter, IDLE/HELD FSM.
// Optional auto-repeat counter in HELD when KEY_AUTOREPEAT_EN is defined.
module key_debounce_cell
    import key_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
`ifdef KEY_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY_CYCLES  = 10,
    parameter int unsigned REPEAT_PERIOD_CYCLES = 5
`endif
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key,
    output logic pressed,
    output logic released,
    output logic held
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]       sync_q;
    logic             s;
    logic             level_q;
    logic             accept_q;
    logic [CNT_W-1:0] cnt_q;

    key_state_e state_q, state_d;
    logic       pressed_d, released_d;

`ifdef KEY_AUTOREPEAT_EN
    localparam int unsigned REP_W      = $clog2(REPEAT_DELAY_CYCLES);
    localparam int unsigned REP_RELOAD = REPEAT_DELAY_CYCLES - REPEAT_PERIOD_CYCLES;
    logic [REP_W-1:0] rep_q, rep_d;
`endif

    assign s    = ~sync_q[1];
    assign held = (state_q == HELD);

    // Synchroniser and stability counter; accept_q flags a newly accepted level for one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= 2'b11;
            level_q  <= 1'b0;
            cnt_q    <= '0;
            accept_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], key};
            accept_q <= 1'b0;
            if (s == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                cnt_q    <= '0;
                level_q  <= s;
                accept_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            pressed  <= 1'b0;
            released <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rep_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pressed  <= pressed_d;
            released <= released_d;
`ifdef KEY_AUTOREPEAT_EN
            rep_q    <= rep_d;
`endif
        end
    end

    // Acceptances alternate, so accept_q alone tells each state to flip.
    always_comb begin
        state_d    = state_q;
        pressed_d  = 1'b0;
        released_d = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        rep_d      = rep_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept_q) begin
                    state_d   = HELD;
                    pressed_d = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                    rep_d     = '0;
`endif
                end
            end
            HELD: begin
                if (accept_q) begin
                    state_d    = IDLE;
                    released_d = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                end else if (rep_q == REP_W'(REPEAT_DELAY_CYCLES - 1)) begin
                    pressed_d = 1'b1;
                    rep_d     = REP_W'(REP_RELOAD);
                end else begin
                    rep_d = rep_q + REP_W'(1);
`endif
                end
            end
        endcase
    end

endmodule

// File: rtl/key_debouncer.sv
// NUM_KEYS independent debounced push buttons for the stopwatch front panel.
// Define KEY_AUTOREPEAT_EN to enable auto-repeat pressed pulses while a key is held.
module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int unsigned NUM_KEYS         = 4,
    parameter int unsigned CLOCK_FREQ       = 50000000,
    parameter int unsigned DEBOUNCE_MS      = 10,
    parameter int unsigned REPEAT_DELAY_MS  = 500,
    parameter int unsigned REPEAT_PERIOD_MS = 100
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] keys,
    output logic [NUM_KEYS-1:0] pressed,
    output logic [NUM_KEYS-1:0] released,
    output logic [NUM_KEYS-1:0] held
);

    localparam int unsigned DEBOUNCE_CYCLES = ms_to_cycles(CLOCK_FREQ, DEBOUNCE_MS);

    // The repeat reload assumes the period never exceeds the initial delay.
    if (REPEAT_PERIOD_MS == 0 || REPEAT_PERIOD_MS > REPEAT_DELAY_MS) begin : g_bad_repeat_cfg
        $error("key_debouncer: REPEAT_PERIOD_MS must be in 1..REPEAT_DELAY_MS");
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce_cell #(
            .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES)
`ifdef KEY_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY_CYCLES (ms_to_cycles(CLOCK_FREQ, REPEAT_DELAY_MS)),
            .REPEAT_PERIOD_CYCLES(ms_to_cycles(CLOCK_FREQ, REPEAT_PERIOD_MS))
`endif
        ) u_cell (
            .clk     (clk),
            .reset_n (reset_n),
            .key     (keys[i]),
            .pressed (pressed[i]),
            .released(released[i]),
            .held    (held[i])
        );
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Randomised and directed bench for key_debouncer against a sliding-window reference model.
module tb_key_debouncer;

    localparam int unsigned NK = 4;
    localparam int unsigned DC = 4;   // 1000 Hz * 4 ms
    localparam int unsigned RD = 10;  // 10 ms repeat delay
    localparam int unsigned RP = 5;   // 5 ms repeat period

    logic          clk     = 1'b0;
    logic          reset_n = 1'b1;
    logic [NK-1:0] keys    = '1;
    logic [NK-1:0] pressed, released, held;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: raw-key pipeline, window of recent synced values, expected outputs.
    bit [NK-1:0] sy1, sy2, lvl, pend_p, pend_r, exp_p, exp_r, exp_h;
    bit [DC-1:0] win  [NK];
    int          nval [NK];
    int          hcnt [NK];

    always #5 clk = ~clk;

    key_debouncer #(
        .NUM_KEYS        (NK),
        .CLOCK_FREQ      (1000),
        .DEBOUNCE_MS     (4),
        .REPEAT_DELAY_MS (10),
        .REPEAT_PERIOD_MS(5)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .keys    (keys),
        .pressed (pressed),
        .released(released),
        .held    (held)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        sy1 = '0; sy2 = '0; lvl = '0;
        pend_p = '0; pend_r = '0;
        exp_p = '0; exp_r = '0; exp_h = '0;
        for (int k = 0; k < NK; k++) begin
            win[k] = '0; nval[k] = 0; hcnt[k] = 0;
        end
    endtask

    // A level is accepted once the last DC synced samples all disagree with it;
    // outputs reflect an acceptance one clock later.
    task automatic model_edge();
        bit s;
        for (int k = 0; k < NK; k++) begin
            s      = sy2[k];
            sy2[k] = sy1[k];
            sy1[k] = ~keys[k];
            exp_p[k] = 1'b0;
            exp_r[k] = 1'b0;
            if (pend_p[k]) begin
                exp_p[k] = 1'b1; exp_h[k] = 1'b1; hcnt[k] = 0;
            end else if (pend_r[k]) begin
                exp_r[k] = 1'b1; exp_h[k] = 1'b0;
            end else if (exp_h[k]) begin
                hcnt[k]++;
`ifdef KEY_AUTOREPEAT_EN
                if (hcnt[k] >= int'(RD) && (hcnt[k] - int'(RD)) % int'(RP) == 0) exp_p[k] = 1'b1;
`endif
            end
            pend_p[k] = 1'b0;
            pend_r[k] = 1'b0;
            win[k] = {win[k][DC-2:0], s};
            if (nval[k] < int'(DC)) nval[k]++;
            if (nval[k] == int'(DC) && s != lvl[k] && win[k] == {DC{s}}) begin
                lvl[k]    = s;
                nval[k]   = 0;
                pend_p[k] = s;
                pend_r[k] = ~s;
            end
        end
    endtask

    // One clock: model the edge, compare at the falling edge, then drive the next key value.
    task automatic step(input logic [NK-1:0] nk);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_eq("pressed", 32'(pressed), 32'(exp_p));
        check_eq("released", 32'(released), 32'(exp_r));
        check_eq("held", 32'(held), 32'(exp_h));
        keys = nk;
    endtask

    task automatic hold_steps(input int n);
        for (int i = 0; i < n; i++) step(keys);
    endtask

    // Wait (bounded) for the first pulse on mask and check its latency and exact value.
    task automatic wait_pulse(input string tag, input logic [NK-1:0] mask, input bit rel,
                              input int exp_lat);
        int lat;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            step(keys);
            if (((rel ? released : pressed) & mask) != '0) begin
                lat = i;
                break;
            end
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_val"}, 32'(rel ? released : pressed), 32'(mask));
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock.
    task automatic apply_reset(input logic [NK-1:0] k_during);
        @(negedge clk);
        #2;
        keys    = k_during;
        reset_n = 1'b0;
        #1;
        check_eq("rst_pressed", 32'(pressed), 32'd0);
        check_eq("rst_released", 32'(released), 32'd0);
        check_eq("rst_held", 32'(held), 32'd0);
        model_reset();
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        int npulse;
        int exp_pulses;
        logic [NK-1:0] nk;
        model_reset();
        repeat (2) @(negedge clk);

        // Reset with all keys down: one simultaneous press after a full debounce.
        apply_reset(4'b0000);
        wait_pulse("rst_press", 4'b1111, 1'b0, 7);
        hold_steps(4);
        step(4'b1111);
        wait_pulse("rel_all", 4'b1111, 1'b1, 7);
        hold_steps(6);

        // Clean press on key 1.
        step(4'b1101);
        wait_pulse("clean_press", 4'b0010, 1'b0, 7);
        hold_steps(13);
        step(4'b1111);
        hold_steps(12);

        // Bouncing key 2: 3 low / 1 high, five times, then low.
        for (int r = 0; r < 5; r++) begin
            step(4'b1011); step(4'b1011); step(4'b1011);
            step(4'b1111);
        end
        step(4'b1011);
        wait_pulse("bounce_press", 4'b0100, 1'b0, 7);
        hold_steps(3);
        step(4'b1111);
        hold_steps(10);

        // Release of key 0 from HELD.
        step(4'b1110);
        hold_steps(12);
        step(4'b1111);
        wait_pulse("release", 4'b0001, 1'b1, 7);
        hold_steps(5);

        // Simultaneous press on keys 3 and 0.
        step(4'b0110);
        wait_pulse("simul", 4'b1001, 1'b0, 7);
        hold_steps(3);
        step(4'b1111);
        hold_steps(12);

        // Long hold on key 1: auto-repeat count depends on the build.
        npulse = 0;
        step(4'b1101);
        for (int i = 0; i < 29; i++) begin
            step(keys);
            if (pressed[1]) npulse++;
        end
`ifdef KEY_AUTOREPEAT_EN
        exp_pulses = 4;
`else
        exp_pulses = 1;
`endif
        check_eq("repeat_count", 32'(npulse), 32'(exp_pulses));
        step(4'b1111);
        hold_steps(12);

        // Reset while key 2 is held: no release, then a fresh press.
        step(4'b1011);
        hold_steps(10);
        apply_reset(4'b1011);
        wait_pulse("rst_held_press", 4'b0100, 1'b0, 7);
        step(4'b1111);
        hold_steps(10);

        // Random key activity with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            nk = keys;
            for (int k = 0; k < NK; k++)
                if ($urandom_range(0, 5) == 0) nk[k] = ~nk[k];
            if ($urandom_range(0, 499) == 0) apply_reset(nk);
            else step(nk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
